regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined RISC-V core. It replaces the single-write, negedge-written register file. Writes are on posedge, with a same-cycle write-to-read bypass instead of the half-cycle trick. It adds N read ports, M write ports, and an integrated busy-bit scoreboard so decode can detect load-use and long-latency hazards. It sits between decode (read and issue side) and writeback (write side).

---
 rtl/rf_pkg.sv | 34 +++
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and the write-port selection helper for the multi-port register file.
// sel_wr works on fixed maximum widths; callers zero-extend their narrower buses.
package rf_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    localparam int MAX_NWR = 4;
    localparam int MAX_AW  = 8;

    localparam logic [MAX_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Highest-indexed enabled write port targeting addr wins; x0 never matches.
    function automatic wr_sel_t sel_wr(input logic [MAX_AW-1:0]         addr,
                                       input logic [MAX_NWR-1:0]        wr_en,
                                       input logic [MAX_NWR*MAX_AW-1:0] wr_addr);
        wr_sel_t sel;
        sel = '0;
        for (int j = 0; j < MAX_NWR; j++) begin
            if (addr != REG_ZERO && wr_en[j] && wr_addr[j*MAX_AW +: MAX_AW] == addr) begin
                sel.hit  = 1'b1;
                sel.port = 2'(j);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per register, set on issue, cleared on writeback.
// A same-cycle issue and writeback to one register leaves it busy for the new producer.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_hit,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // A forwarded write already satisfies the reader, so it no longer sees the register as busy.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = !rst && busy[rd_addr[k*AW +: AW]]
                         && !((BYPASS != 0) && rd_hit[k]);
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with posedge writes, optional same-cycle write-to-read
// forwarding, a hardwired-zero x0 and an integrated busy-bit scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0]           rf [NREG];
    logic [MAX_NWR-1:0]        en_pad;
    logic [MAX_NWR*MAX_AW-1:0] wa_pad;
    logic [NRD-1:0]            rd_hit;

    // Later ports overwrite earlier ones, giving the higher index priority on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    rf[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    assign en_pad = MAX_NWR'(wr_en);

    always_comb begin
        wa_pad = '0;
        for (int j = 0; j < NWR; j++)
            wa_pad[j*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[j*AW +: AW]);
    end

    always_comb begin
        logic [AW-1:0] ra;
        wr_sel_t       sel;
        rd_data = '0;
        rd_hit  = '0;
        for (int k = 0; k < NRD; k++) begin
            ra        = rd_addr[k*AW +: AW];
            sel       = sel_wr(MAX_AW'(ra), en_pad, wa_pad);
            rd_hit[k] = sel.hit && !rst;
            if (ra == '0)
                rd_data[k*XLEN +: XLEN] = '0;
            else if ((BYPASS != 0) && rd_hit[k])
                rd_data[k*XLEN +: XLEN] = wr_data[int'(sel.port)*XLEN +: XLEN];
            else
                rd_data[k*XLEN +: XLEN] = rf[ra];
        end
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rd_addr  (rd_addr),
        .rd_hit   (rd_hit),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share one stimulus stream
// and are compared every cycle against an architectural model of registers and busy bits.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;

    logic [63:0] rd_data_a, rd_data_nb;
    logic [1:0]  rd_busy_a, rd_busy_nb;
    logic [31:0] busy_vec_a, busy_vec_nb;

    logic [31:0] m_rf [32];
    bit          m_busy [32];
    bit          model_valid = 0;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_a)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic ie, input logic [4:0] ir,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        @(posedge clk);
        #1;
        rst     = r;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        iss_en  = ie;
        iss_rd  = ir;
        rd_addr = {ra1, ra0};
    endtask

    // Architectural meaning of a read: x0 is zero, a same-cycle write is visible when
    // forwarding (highest write port first), otherwise the stored value.
    function automatic logic [31:0] expRead(int k, bit byp);
        logic [4:0] a = rd_addr[k*5 +: 5];
        if (a == 5'd0) return 32'd0;
        if (byp && !rst) begin
            for (int j = 1; j >= 0; j--)
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) return wr_data[j*32 +: 32];
        end
        return m_rf[a];
    endfunction

    function automatic logic expBusy(int k, bit byp);
        logic [4:0] a = rd_addr[k*5 +: 5];
        if (rst) return 1'b0;
        if (byp) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    function automatic logic [31:0] expVec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i]   <= '0;
                m_busy[i] <= 1'b0;
            end
            model_valid <= 1'b1;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
                    m_rf[wr_addr[j*5 +: 5]]   <= wr_data[j*32 +: 32];
                    m_busy[wr_addr[j*5 +: 5]] <= 1'b0;
                end
            end
            if (iss_en && iss_rd != 5'd0)
                m_busy[iss_rd] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput("byp_rd_data", rd_data_a[k*32 +: 32], expRead(k, 1'b1));
                checkOutput("nob_rd_data", rd_data_nb[k*32 +: 32], expRead(k, 1'b0));
                checkOutput("byp_rd_busy", 32'(rd_busy_a[k]), 32'(expBusy(k, 1'b1)));
                checkOutput("nob_rd_busy", 32'(rd_busy_nb[k]), 32'(expBusy(k, 1'b0)));
            end
            checkOutput("byp_busy_vec", busy_vec_a, expVec());
            checkOutput("nob_busy_vec", busy_vec_nb, expVec());
        end
    end

    initial begin
        rst = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
        iss_en = 1'b0; iss_rd = 5'd0; rd_addr = {5'd0, 5'd5};

        applyStimulus(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
        @(negedge clk);
        checkOutput("rst_no_bypass", rd_data_a[31:0], 32'd0);
        checkOutput("rst_no_busy", 32'(rd_busy_a), 32'd0);

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
        @(negedge clk);
        checkOutput("x5_after_rst", rd_data_a[31:0], 32'd0);
        checkOutput("busy_vec_rst", busy_vec_a, 32'd0);

        for (int a = 0; a < 32; a++) begin
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            @(negedge clk);
            checkOutput("rst_read_p0", rd_data_a[31:0], 32'd0);
            checkOutput("rst_read_p1", rd_data_nb[63:32], 32'd0);
        end

        applyStimulus(0, 2'b01, 0, 32'h12345678, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("x0_same_cycle", rd_data_a[31:0], 32'd0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("x0_next_cycle", rd_data_a[31:0], 32'd0);
        checkOutput("x0_never_busy", busy_vec_a, 32'd0);

        applyStimulus(0, 2'b01, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("x7_bypass", rd_data_a[31:0], 32'hA5A5A5A5);
        checkOutput("x7_no_bypass", rd_data_nb[31:0], 32'd0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("x7_stored_byp", rd_data_a[31:0], 32'hA5A5A5A5);
        checkOutput("x7_stored_nob", rd_data_nb[31:0], 32'hA5A5A5A5);

        applyStimulus(0, 2'b11, 3, 32'h1111, 3, 32'h2222, 0, 0, 3, 3);
        @(negedge clk);
        checkOutput("x3_collide_byp", rd_data_a[63:32], 32'h2222);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        checkOutput("x3_collide_stored", rd_data_nb[31:0], 32'h2222);

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("x9_busy_vec", busy_vec_a, 32'h0000_0200);
        checkOutput("x9_rd_busy", 32'(rd_busy_a), 32'd2);
        applyStimulus(0, 2'b01, 9, 32'h55, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("x9_wb_busy_byp", 32'(rd_busy_a), 32'd0);
        checkOutput("x9_wb_busy_nob", 32'(rd_busy_nb), 32'd2);
        checkOutput("x9_wb_data", rd_data_a[63:32], 32'h55);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("x9_cleared", busy_vec_a, 32'd0);
        checkOutput("x9_stored", rd_data_nb[63:32], 32'h55);

        applyStimulus(0, 2'b01, 4, 32'h99, 0, 0, 1, 4, 4, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk);
        checkOutput("x4_data", rd_data_a[31:0], 32'h99);
        checkOutput("x4_set_wins", busy_vec_a, 32'h0000_0010);
        checkOutput("x4_rd_busy", 32'(rd_busy_nb), 32'd1);

        // Mixed traffic: overlapping writes, issues and reads exercised against the model.
        for (int i = 0; i < 24; i++) begin
            logic [4:0] wa0, wa1;
            wa0 = 5'((i * 7 + 1) % 32);
            wa1 = (i % 4 == 3) ? wa0 : 5'((i * 3 + 2) % 32);
            applyStimulus(0, 2'(i), wa0, 32'h1000_0000 + 32'(i) * 32'h0101,
                          wa1, 32'h2000_0000 + 32'(i), (i % 3 == 0), 5'((i * 11) % 32),
                          wa0, 5'((i * 11) % 32));
        end

        applyStimulus(1, 2'b01, 9, 32'hFFFF, 0, 0, 1, 6, 9, 4);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 4);
        @(negedge clk);
        checkOutput("rerst_x9", rd_data_a[31:0], 32'd0);
        checkOutput("rerst_x4", rd_data_nb[63:32], 32'd0);
        checkOutput("rerst_busy", busy_vec_a, 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
